bus_dest_regs: RTL

- Destination/write end of the 32-bit CPU data bus.
- Where the source mux picks which register drives the bus, this block takes the bus value and loads it into one register on the clock edge. The target is chosen by a 5-bit destination code that reuses the source encoding.
- Holds R0–R15, HI, LO, PC, MDR, OutPort, IR, MAR and Y. Every register's current value goes back out to the source mux and the datapath.

---
 rtl/bus_pkg.sv | 63 ++++++
 rtl/reg_en_32.sv | 43 ++++
 rtl/bus_dest_regs.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared constants for the 32-bit CPU data bus. Source and destination
// registers share one 5-bit code space, so the same localparams serve both
// the source mux and the destination (write) block.
//
// Contents:
//   BUS_DATA_W          default bus/register width
//   REG_*               5-bit source/destination codes
//   is_writable_dest()  1 when a code names a register the bus may load
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_DATA_W = 32;

  localparam logic [4:0] REG_R0      = 5'd0;
  localparam logic [4:0] REG_R1      = 5'd1;
  localparam logic [4:0] REG_R2      = 5'd2;
  localparam logic [4:0] REG_R3      = 5'd3;
  localparam logic [4:0] REG_R4      = 5'd4;
  localparam logic [4:0] REG_R5      = 5'd5;
  localparam logic [4:0] REG_R6      = 5'd6;
  localparam logic [4:0] REG_R7      = 5'd7;
  localparam logic [4:0] REG_R8      = 5'd8;
  localparam logic [4:0] REG_R9      = 5'd9;
  localparam logic [4:0] REG_R10     = 5'd10;
  localparam logic [4:0] REG_R11     = 5'd11;
  localparam logic [4:0] REG_R12     = 5'd12;
  localparam logic [4:0] REG_R13     = 5'd13;
  localparam logic [4:0] REG_R14     = 5'd14;
  localparam logic [4:0] REG_R15     = 5'd15;
  localparam logic [4:0] REG_HI      = 5'd16;
  localparam logic [4:0] REG_LO      = 5'd17;
  localparam logic [4:0] REG_ZHI     = 5'd18;
  localparam logic [4:0] REG_ZLO     = 5'd19;
  localparam logic [4:0] REG_PC      = 5'd20;
  localparam logic [4:0] REG_MDR     = 5'd21;
  // InPort drives the bus as a source; OutPort is loaded as a destination.
  localparam logic [4:0] REG_INPORT  = 5'd22;
  localparam logic [4:0] REG_OUTPORT = 5'd22;
  localparam logic [4:0] REG_C       = 5'd23;
  localparam logic [4:0] REG_IR      = 5'd24;
  localparam logic [4:0] REG_MAR     = 5'd25;
  localparam logic [4:0] REG_Y       = 5'd26;

  // Zhi/Zlo are loaded only by the ALU and C is a read-only sign-extended
  // constant, so those codes (and 27-31) are not valid bus destinations.
  function automatic logic is_writable_dest(input logic [4:0] code);
    logic ok;
    ok = 1'b0;
    if (code <= REG_R15) ok = 1'b1;
    else begin
      case (code)
        REG_HI, REG_LO, REG_PC, REG_MDR, REG_OUTPORT,
        REG_IR, REG_MAR, REG_Y:         ok = 1'b1;
        REG_ZHI, REG_ZLO, REG_C:        ok = 1'b0;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_en_32.sv
// ---------------------------------------------------------------------------
// reg_en_32
// DATA_W-wide storage register with synchronous clear and load enable.
//
// Parameters:
//   DATA_W     register width
//   RESET_VAL  value loaded when clr is high at the clock edge
// Ports:
//   clk  in   clock, rising edge
//   clr  in   synchronous active-high clear (overrides en)
//   en   in   load enable
//   d    in   data to load
//   q    out  current register value
// ---------------------------------------------------------------------------
module reg_en_32
  import bus_pkg::*;
#(
  parameter int                 DATA_W    = BUS_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bus_dest_regs.sv
// ---------------------------------------------------------------------------
// bus_dest_regs
// Write end of the CPU data bus: loads bus_data into the register named by
// dest_sel on the rising edge, and exposes every register to the datapath.
// PC has its own increment path and MDR its own memory-load path; both can
// update in the same cycle as an unrelated bus write.
//
// Optional build macro BUS_DEST_TRACE_EN adds last_dest / wr_count /
// last_data, which record valid bus writes.
//
// Ports:
//   clk, clr                 clock / synchronous active-high reset
//   bus_data, dest_we,       bus value, write strobe, destination code
//   dest_sel
//   pc_inc                   PC <= PC + 1 (a bus write to PC wins)
//   mdr_read, mem_data_in    MDR <= memory data (wins over a bus write)
//   ba_out                   forces the R0 slice of r_busout to zero
//   r_busout                 R0..R15, R0 in the low DATA_W bits
//   hi_out .. y_out          special register values
//   illegal_wr               sticky flag: write to a reserved code
// ---------------------------------------------------------------------------
module bus_dest_regs
  import bus_pkg::*;
#(
  parameter int                DATA_W   = BUS_DATA_W,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [DATA_W-1:0]      bus_data,
  input  logic                   dest_we,
  input  logic [4:0]             dest_sel,
  input  logic                   pc_inc,
  input  logic                   mdr_read,
  input  logic [DATA_W-1:0]      mem_data_in,
  input  logic                   ba_out,
  output logic [16*DATA_W-1:0]   r_busout,
  output logic [DATA_W-1:0]      hi_out,
  output logic [DATA_W-1:0]      lo_out,
  output logic [DATA_W-1:0]      pc_out,
  output logic [DATA_W-1:0]      mdr_out,
  output logic [DATA_W-1:0]      outport_out,
  output logic [DATA_W-1:0]      ir_out,
  output logic [DATA_W-1:0]      mar_out,
  output logic [DATA_W-1:0]      y_out,
`ifdef BUS_DEST_TRACE_EN
  output logic [4:0]             last_dest,
  output logic [15:0]            wr_count,
  output logic [DATA_W-1:0]      last_data,
`endif
  output logic                   illegal_wr
);

  logic                         wr_valid;
  logic [15:0]                  r_en;
  logic [15:0][DATA_W-1:0]      r_q;
  logic                         pc_en;
  logic [DATA_W-1:0]            pc_d;
  logic                         mdr_en;
  logic [DATA_W-1:0]            mdr_d;
  logic                         illegal_wr_q;
  logic                         illegal_wr_d;

  // Decode the destination strobe; reserved codes never enable a register.
  always_comb begin
    wr_valid = dest_we && is_writable_dest(dest_sel);
    for (int i = 0; i < 16; i++) begin
      r_en[i] = wr_valid && (dest_sel == 5'(i));
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
    reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_r (
      .clk (clk),
      .clr (clr),
      .en  (r_en[gi]),
      .d   (bus_data),
      .q   (r_q[gi])
    );
  end

  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_hi (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_HI),
    .d(bus_data), .q(hi_out));
  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_lo (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_LO),
    .d(bus_data), .q(lo_out));
  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_outport (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_OUTPORT),
    .d(bus_data), .q(outport_out));
  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_ir (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_IR),
    .d(bus_data), .q(ir_out));
  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_mar (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_MAR),
    .d(bus_data), .q(mar_out));
  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_y (
    .clk(clk), .clr(clr), .en(wr_valid && dest_sel == REG_Y),
    .d(bus_data), .q(y_out));

  // PC: a bus write takes priority over the increment; the add wraps.
  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc_out;
    if (wr_valid && dest_sel == REG_PC) begin
      pc_en = 1'b1;
      pc_d  = bus_data;
    end else if (pc_inc) begin
      pc_en = 1'b1;
      pc_d  = pc_out + DATA_W'(1);
    end
  end

  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL(PC_RESET)) u_pc (
    .clk(clk), .clr(clr), .en(pc_en), .d(pc_d), .q(pc_out));

  // MDR: the memory load takes priority over a bus write.
  always_comb begin
    mdr_en = 1'b0;
    mdr_d  = bus_data;
    if (mdr_read) begin
      mdr_en = 1'b1;
      mdr_d  = mem_data_in;
    end else if (wr_valid && dest_sel == REG_MDR) begin
      mdr_en = 1'b1;
    end
  end

  reg_en_32 #(.DATA_W(DATA_W), .RESET_VAL('0)) u_mdr (
    .clk(clk), .clr(clr), .en(mdr_en), .d(mdr_d), .q(mdr_out));

  // R0 gating only affects what leaves the block; the stored R0 is intact.
  always_comb begin
    r_busout               = r_q;
    r_busout[DATA_W-1:0]   = ba_out ? '0 : r_q[0];
  end

  always_comb begin
    illegal_wr_d = illegal_wr_q | (dest_we & ~is_writable_dest(dest_sel));
  end

  always_ff @(posedge clk) begin
    if (clr) illegal_wr_q <= 1'b0;
    else     illegal_wr_q <= illegal_wr_d;
  end

  assign illegal_wr = illegal_wr_q;

`ifdef BUS_DEST_TRACE_EN
  logic [4:0]        last_dest_q;
  logic [4:0]        last_dest_d;
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic [DATA_W-1:0] last_data_q;
  logic [DATA_W-1:0] last_data_d;

  // Only valid bus writes are traced; PC increments and MDR loads are not.
  always_comb begin
    last_dest_d = last_dest_q;
    wr_count_d  = wr_count_q;
    last_data_d = last_data_q;
    if (wr_valid) begin
      last_dest_d = dest_sel;
      wr_count_d  = wr_count_q + 16'd1;
      last_data_d = bus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      last_dest_q <= '0;
      wr_count_q  <= '0;
      last_data_q <= '0;
    end else begin
      last_dest_q <= last_dest_d;
      wr_count_q  <= wr_count_d;
      last_data_q <= last_data_d;
    end
  end

  assign last_dest = last_dest_q;
  assign wr_count  = wr_count_q;
  assign last_data = last_data_q;
`endif

endmodule
